mem_word_reader: RTL
====================

# mem_word_reader

Read-side controller for the 8-bit-wide, 1024-deep shared game memory. Arbitrates between two word requesters (0: RNG, 1: winner policy), drives the select of the existing 2:1 word-address mux, then performs two byte reads and returns the assembled 16-bit word to the granted requester. It sits between the requesters and the synchronous memory and owns every read access.

## Interface
- MEM_DEPTH, 1024, memory depth in bytes
- MEM_WIDTH, 8, memory data width
- WORD_WIDTH, 16, requester word/address width
- ADDR_WIDTH, 10, memory byte-address width

- clk  in  1  system clock, rising edge
- nrst  in  1  reset; one clock; asynchronous, active-low
- req0  in  1  read request, requester 0 (RNG)
- req1  in  1  read request, requester 1 (winner policy)
- sel  out  1  select to the external word-address mux (0 → addr0, 1 → addr1)
- waddr  in  WORD_WIDTH  word address returned by that mux
- grant0 / grant1  out  1  one-cycle grant pulse
- valid0 / valid1  out  1  one-cycle read-data-valid pulse
- rdata  out  WORD_WIDTH  assembled word, shared by both requesters
- mem_rd  out  1  memory read enable
- mem_addr  out  ADDR_WIDTH  memory byte address
- mem_rdata  in  MEM_WIDTH  memory data, valid the cycle after mem_rd

## Operation
- States: IDLE, RD0, RD1, CAP.
- IDLE: samples req0/req1. No request → stay. Request → pick winner, sel<=winner, grantN<=1, latch owner, go RD0.
- Arbitration: round robin on last-served pointer. Single request wins unconditionally. Both requests → the one not served last. Pointer reset value makes requester 0 win the first tie.
- RD0: mem_rd=1, mem_addr={waddr[8:0],1'b0} (live mux output); waddr latched at end of cycle; go RD1.
- RD1: mem_rd=1, mem_addr={latched[8:0],1'b1}; low byte<=mem_rdata; go CAP.
- CAP: mem_rd=0; rdata<={mem_rdata, low byte}; valid<owner><=1; go IDLE.
- Address: waddr[15:9] ignored (wraps within 512 words). Low byte at even address, high byte at odd.
- Requester rules: hold req and its address stable until grant; keep address stable through the grant cycle; deassert req by the cycle after grant, otherwise it is treated as a new request at the next IDLE.
- rdata holds its last value until the next CAP; only valid qualifies it.
- req dropped before being granted: not served, no pulses.

## Timing
- Reset (nrst=0, asynchronous): state IDLE; sel, grant0/1, valid0/1, mem_rd = 0; rdata = 0; mem_addr = 0; pointer = "last served 1". Mid-transfer reset aborts the read; no valid is issued.
- Edge 0 (IDLE, req seen) → cycle 1 (RD0): grant high, sel = owner, mem_rd high.
- Cycle 2 (RD1): second read; cycle 3 (CAP): mem_rd low.
- Cycle 4: validN high, rdata valid; block is in IDLE and samples requests at the end of this cycle.
- Latency from req sampled to valid: 4 cycles. Sustained throughput: one word per 4 cycles.
- sel changes only when leaving IDLE with a grant; it otherwise holds the last owner.
- grant0 & grant1, and valid0 & valid1, are never high together.
- Outside RD0/RD1: mem_rd=0; mem_addr holds {latched[8:0],1}.

## Test plan
- Reset, then req0=1 with addr0=0x0005; memory[10]=0x34, [11]=0x12 → grant0 in cycle 1, mem_addr 10 then 11, valid0 in cycle 4 with rdata=0x1234; grant1/valid1 stay 0.
- req0 and req1 asserted together, held high for three services → order 0, 1, 0; sel follows; each valid goes to the matching requester.
- req1 only, repeated back-to-back (drop after grant, reassert) → every service goes to 1; grant spacing 4 cycles.
- addr1=0xFE03 → waddr[15:9] ignored; mem_addr 6 then 7.
- nrst pulsed low during RD1 → all outputs 0 immediately, no valid pulse; the next req0 completes normally with 4-cycle latency.
- req0 pulsed for one cycle while a req1 service is in RD0 → req0 not served, no grant0.

Source files
------------

// File: rtl/mem_word_reader.sv
// Read-side controller for the shared byte-wide game memory: round-robin arbitration between two
// word requesters, followed by two byte reads assembled into one 16-bit little-endian word.
module mem_word_reader #(
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned MEM_WIDTH  = 8,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  req0,
  input  logic                  req1,
  output logic                  sel,
  input  logic [WORD_WIDTH-1:0] waddr,
  output logic                  grant0,
  output logic                  grant1,
  output logic                  valid0,
  output logic                  valid1,
  output logic [WORD_WIDTH-1:0] rdata,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [MEM_WIDTH-1:0]  mem_rdata
);

  // Number of word-index bits; upper waddr bits wrap within the memory.
  localparam int unsigned WordIdxW = $clog2(MEM_DEPTH) - 1;

  typedef enum logic [1:0] {StIdle, StRd0, StRd1, StCap} state_e;

  state_e                  state_q, state_d;
  logic                    sel_q, sel_d;
  logic                    last_q, last_d;
  logic                    grant0_q, grant0_d, grant1_q, grant1_d;
  logic                    valid0_q, valid0_d, valid1_q, valid1_d;
  logic [ADDR_WIDTH-1:0]   hold_q, hold_d;
  logic [MEM_WIDTH-1:0]    lo_q, lo_d;
  logic [WORD_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    winner;
  logic                    unused_waddr_hi;

  assign unused_waddr_hi = ^waddr[WORD_WIDTH-1:WordIdxW];

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    valid0_d = 1'b0;
    valid1_d = 1'b0;
    hold_d   = hold_q;
    lo_d     = lo_q;
    rdata_d  = rdata_q;
    mem_rd   = 1'b0;
    mem_addr = hold_q;
    // On a tie the requester not served last wins; otherwise the lone requester wins.
    winner   = (req0 && req1) ? ~last_q : req1;

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d  = StRd0;
          sel_d    = winner;
          last_d   = winner;
          grant0_d = ~winner;
          grant1_d = winner;
        end
      end
      StRd0: begin
        mem_rd   = 1'b1;
        mem_addr = {waddr[WordIdxW-1:0], 1'b0};
        hold_d   = {waddr[WordIdxW-1:0], 1'b1};
        state_d  = StRd1;
      end
      StRd1: begin
        mem_rd  = 1'b1;
        lo_d    = mem_rdata;
        state_d = StCap;
      end
      StCap: begin
        rdata_d  = {mem_rdata, lo_q};
        valid0_d = ~sel_q;
        valid1_d = sel_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StIdle;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      hold_q   <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      hold_q   <= hold_d;
      lo_q     <= lo_d;
      rdata_q  <= rdata_d;
    end
  end

  assign sel    = sel_q;
  assign grant0 = grant0_q;
  assign grant1 = grant1_q;
  assign valid0 = valid0_q;
  assign valid1 = valid1_q;
  assign rdata  = rdata_q;

endmodule
